// File: rtl/sci_alu_issue_queue.sv
// sci_alu_issue_queue: buffers ALU requests in a small FIFO and issues them one
// at a time to a latched scientific ALU. Each operation gets a clean enable pulse,
// then the latched result and flags are captured and offered via valid/ready.
module sci_alu_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int ALU_WAIT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_opcode,
    input  logic [63:0]             in_a,
    input  logic [63:0]             in_b,
    output logic                    alu_enable,
    output logic [63:0]             alu_a,
    output logic [63:0]             alu_b,
    output logic [3:0]              alu_opcode,
    input  logic [63:0]             alu_result,
    input  logic                    alu_excep,
    input  logic                    alu_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [63:0]             out_result,
    output logic                    out_excep,
    output logic                    out_err,
    output logic [3:0]              out_opcode,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL      = LW'(DEPTH);
    localparam logic [3:0]    WAIT_INIT = 4'(ALU_WAIT);

    // One FIFO entry: opcode plus both operands.
    typedef struct packed {
        logic [3:0]  opcode;
        logic [63:0] a;
        logic [63:0] b;
    } entry_t;

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, HOLD} state_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    state_t        state;
    logic [3:0]    wait_cnt;
    logic          push;
    logic          pop;
    entry_t        head;
    entry_t        wr_entry;

    // Ready comes only from the registered occupancy, never from in_valid.
    assign in_ready = (level != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (level != '0);
    assign head     = mem[rd_ptr];

    always_comb begin
        wr_entry        = '0;
        wr_entry.opcode = in_opcode;
        wr_entry.a      = in_a;
        wr_entry.b      = in_b;
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end

    // Pointers wrap naturally since DEPTH is a power of two; level tracks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Issue FSM. The pop edge loads the operand registers with enable still low,
    // so the ALU sees settled operands for the whole ALU_WAIT+1 cycle transparent
    // window; dropping enable latches the result, which is captured one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            alu_enable <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_excep  <= 1'b0;
            out_err    <= 1'b0;
            out_opcode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    alu_enable <= 1'b0;
                    if (pop) begin
                        alu_a      <= head.a;
                        alu_b      <= head.b;
                        alu_opcode <= head.opcode;
                        wait_cnt   <= WAIT_INIT;
                        state      <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!alu_enable) begin
                        alu_enable <= 1'b1;
                    end else if (wait_cnt == '0) begin
                        alu_enable <= 1'b0;
                        state      <= LATCH;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                LATCH: begin
                    out_result <= alu_result;
                    out_excep  <= alu_excep;
                    out_err    <= alu_err;
                    out_opcode <= alu_opcode;
                    out_valid  <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    alu_enable <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Occupancy can never exceed the buffer size.
    property p_level_bound;
        @(posedge clk) disable iff (!rst_n) level <= FULL;
    endproperty
    a_level_bound: assert property (p_level_bound);

    // The ALU is never transparent while a captured result is on offer.
    property p_enable_exclusive;
        @(posedge clk) disable iff (!rst_n) !(alu_enable && out_valid);
    endproperty
    a_enable_exclusive: assert property (p_enable_exclusive);

endmodule

// File: tb/tb_sci_alu_issue_queue.sv
// Self-checking bench for sci_alu_issue_queue: behavioural latched-ALU stub,
// scoreboard of expected results, and a cycle monitor for timing properties.
module tb_sci_alu_issue_queue;
    localparam int DEPTH    = 4;
    localparam int ALU_WAIT = 1;
    localparam int LW       = $clog2(DEPTH) + 1;

    localparam logic [63:0] F16 = 64'h4030000000000000;
    localparam logic [63:0] F2  = 64'h4000000000000000;
    localparam logic [63:0] F0  = 64'h0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_opcode = '0;
    logic [63:0]   in_a = '0;
    logic [63:0]   in_b = '0;
    logic          alu_enable;
    logic [63:0]   alu_a;
    logic [63:0]   alu_b;
    logic [3:0]    alu_opcode;
    logic [63:0]   alu_result = '0;
    logic          alu_excep = 1'b0;
    logic          alu_err = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_result;
    logic          out_excep;
    logic          out_err;
    logic [3:0]    out_opcode;
    logic [LW-1:0] level;

    always #5 clk = ~clk;

    sci_alu_issue_queue #(.DEPTH(DEPTH), .ALU_WAIT(ALU_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_a(in_a), .in_b(in_b),
        .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_excep(alu_excep), .alu_err(alu_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_excep(out_excep), .out_err(out_err), .out_opcode(out_opcode),
        .level(level)
    );

    // Stand-in ALU function: {excep, err, result}; divide-by-zero style flags on op F.
    function automatic logic [65:0] alu_f(input logic [3:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0] r;
        logic        er;
        logic        ex;
        r  = (a + {b[31:0], b[63:32]}) ^ {op, 60'h0} ^ {60'h0, op};
        er = (op == 4'hF) && (b == 64'h0);
        ex = er || (a[63] != b[63]);
        return {ex, er, r};
    endfunction

    // Latched ALU stub: follows its inputs while enabled, holds otherwise.
    always @(posedge clk) begin
        if (alu_enable) {alu_excep, alu_err, alu_result} <= alu_f(alu_opcode, alu_a, alu_b);
    end

    typedef struct {
        logic [3:0]  op;
        logic [63:0] res;
        logic        excep;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor state
    int            ns, en_len, en_rise_ns, hs_ns, last_v_ns, n_coinc, n_vrise, max_lvl;
    bit            en_prev, v_prev, pend_hs, chk_tput, saw_full_block;
    logic [LW-1:0] lvl_h [4];
    bit            push_h [4];

    // Cycle monitor: level model, enable pulse width, latencies, scoreboard compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            ns = 0; en_len = 0; en_prev = 0; v_prev = 0; pend_hs = 0;
        end else begin
            bit en_rise;
            bit v_rise;
            en_rise = alu_enable && !en_prev;
            v_rise  = out_valid && !v_prev;
            lvl_h[ns & 3]  = level;
            push_h[ns & 3] = in_valid && in_ready;
            if (ns >= 2) begin
                int el;
                el = int'(lvl_h[(ns-2) & 3]) + int'(push_h[(ns-2) & 3]) - int'(en_rise);
                ck("level_step", 64'(lvl_h[(ns-1) & 3]), 64'(el));
                if (en_rise && push_h[(ns-2) & 3]) n_coinc++;
            end
            ck("in_ready", 64'(in_ready), 64'(level != LW'(DEPTH)));
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (in_valid && !in_ready) saw_full_block = 1;
            if (alu_enable) en_len++;
            else if (en_len != 0) begin
                ck("en_pulse", 64'(en_len), 64'(ALU_WAIT + 1));
                en_len = 0;
            end
            if (en_rise) begin
                if (pend_hs) ck("hs_to_pop", 64'(ns - hs_ns), 64'(3));
                pend_hs = 0;
                en_rise_ns = ns;
            end
            if (v_rise) begin
                n_vrise++;
                ck("latency", 64'(ns - en_rise_ns), 64'(ALU_WAIT + 2));
                if (chk_tput && last_v_ns >= 0) ck("period", 64'(ns - last_v_ns), 64'(ALU_WAIT + 5));
                last_v_ns = ns;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) ck("sb_empty", 64'(1), 64'(0));
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    ck("result", out_result, e.res);
                    ck("opcode", 64'(out_opcode), 64'(e.op));
                    ck("excep", 64'(out_excep), 64'(e.excep));
                    ck("err", 64'(out_err), 64'(e.err));
                end
                hs_ns = ns;
                pend_hs = (level != '0);
            end
            en_prev = alu_enable;
            v_prev  = out_valid;
            ns++;
        end
    end

    int cyc = 0;
    // All stimulus runs in the posedge+1 phase.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [65:0] f;
        bit          done;
        done = 0;
        in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                f = alu_f(op, a, b);
                e.op = op; e.res = f[63:0]; e.err = f[64]; e.excep = f[65];
                sb.push_back(e);
                done = 1;
            end
        end
        if (!done) ck("timeout_push", 64'(0), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 500) begin tick(); t++; end
        if (!out_valid) ck("timeout_valid", 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || level != '0 || out_valid || alu_enable) && t < 3000) begin
            tick(); t++;
        end
        if (t >= 3000) ck("timeout_idle", 64'(0), 64'(1));
        repeat (3) tick();
    endtask

    task automatic ck_reset_outputs(input string tag);
        ck({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        ck({tag, "_level"}, 64'(level), 64'(0));
        ck({tag, "_alu_enable"}, 64'(alu_enable), 64'(0));
        ck({tag, "_alu_a"}, alu_a, 64'(0));
        ck({tag, "_alu_b"}, alu_b, 64'(0));
        ck({tag, "_alu_opcode"}, 64'(alu_opcode), 64'(0));
        ck({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        ck({tag, "_out_result"}, out_result, 64'(0));
        ck({tag, "_out_flags"}, 64'({out_excep, out_err}), 64'(0));
        ck({tag, "_out_opcode"}, 64'(out_opcode), 64'(0));
    endtask

    initial begin
        int p, v, t, c0, v0;
        logic [63:0] held_res;
        logic [3:0]  held_op;

        // Power-on reset
        repeat (2) tick();
        ck_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single operation: pop-to-valid latency
        out_ready = 1'b1;
        push_op(4'h0, F16, F2);
        t = 0;
        while (level != '0 && t < 100) begin tick(); t++; end
        p = cyc;
        while (!out_valid && t < 200) begin tick(); t++; end
        v = cyc;
        ck("single_latency", 64'(v - p), 64'(ALU_WAIT + 3));
        ck("single_opcode", 64'(out_opcode), 64'(0));
        wait_idle();

        // All opcodes in order, full throughput
        chk_tput = 1; last_v_ns = -1; max_lvl = 0; saw_full_block = 0;
        for (int i = 0; i < 16; i++) push_op(4'(i), F16, F2);
        wait_idle();
        chk_tput = 0;
        ck("level_peak", 64'(max_lvl), 64'(DEPTH));
        ck("full_blocks", 64'(saw_full_block), 64'(1));

        // Backpressure: outputs frozen, FIFO fills, no further pop
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_op(4'(i + 3), F16 + 64'(i), F2);
        wait_valid();
        held_res = out_result;
        held_op  = out_opcode;
        for (int i = 0; i < 20; i++) begin
            tick();
            ck("bp_result", out_result, held_res);
            ck("bp_opcode", 64'(out_opcode), 64'(held_op));
            ck("bp_level", 64'(level), 64'(DEPTH));
            ck("bp_in_ready", 64'(in_ready), 64'(0));
            ck("bp_no_enable", 64'(alu_enable), 64'(0));
        end
        out_ready = 1'b1;
        wait_idle();

        // Push on the pop edge, pointers wrap, order preserved
        c0 = n_coinc;
        push_op(4'h1, 64'h11, F2);
        push_op(4'h2, 64'h22, F2);
        for (int i = 0; i < 10; i++) begin
            wait_valid();
            tick();
            push_op(4'(i + 5), 64'(i * 64'h1000 + 7), F16);
        end
        wait_idle();
        ck("coincident_push_pop", 64'(n_coinc - c0 >= 10), 64'(1));

        // Error capture: flags held until handshake
        out_ready = 1'b0;
        push_op(4'hF, F16, F0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            ck("err_hold", 64'(out_err), 64'(1));
            ck("excep_hold", 64'(out_excep), 64'(1));
        end
        out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of DRIVE
        push_op(4'h3, F2, F16);
        t = 0;
        while (!alu_enable && t < 50) begin tick(); t++; end
        if (!alu_enable) ck("timeout_drive", 64'(0), 64'(1));
        #2 rst_n = 1'b0;
        #1 ck_reset_outputs("mid_rst");
        repeat (2) tick();
        sb.delete();
        v0 = n_vrise;
        rst_n = 1'b1;
        repeat (20) tick();
        ck("no_valid_after_rst", 64'(n_vrise - v0), 64'(0));
        ck("level_after_rst", 64'(level), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
